pio_capture_bank: RTL and testbench
===================================

Name: pio_capture_bank

Overview:
- Parametrised Avalon-MM PIO bank that replaces the per-peripheral single-channel PIOs (LEDs, switches, push buttons, hex displays, IR, LCD, fan).
- Provides NUM_CH channels of WIDTH bits. Each channel has:
  - a synchronised, debounced input;
  - a set/clear-addressable output register;
  - per-bit edge capture with runtime-selectable edge mode;
  - a maskable interrupt.
- Sits on the PCIe-bridged Avalon-MM fabric. One instance serves all board I/O.

Parameters:
- NUM_CH, 4: number of channels (1..16).
- WIDTH, 32: bits per channel (1..32).
- DEBOUNCE_CYCLES, 50000: input must be stable this many clk cycles before being accepted. 0 = bypass debounce.
- OUT_RESET, 0: reset value of every DATA_OUT register (WIDTH bits).
- ADDR_W, $clog2(NUM_CH)+3: word address width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- avs_address  in  ADDR_W  word address: {channel, reg[2:0]}.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, valid the cycle after avs_read.
- in_port  in  NUM_CH*WIDTH  asynchronous inputs; channel c occupies bits [c*WIDTH +: WIDTH].
- out_port  out  NUM_CH*WIDTH  output registers, packed the same way.
- irq  out  1  level interrupt.

Behaviour:
- All state is clocked on the rising edge of clk. Reset is synchronous and active-high.
- Reset values:
  - avs_readdata=0, irq=0, out_port=OUT_RESET per channel.
  - Sync, debounce and stable registers = 0.
  - EDGE_CAP=0, IRQ_MASK=0, EDGE_CFG=0 (rising).
  - Debounce counters=0.
- Register map, per channel, reg offset:
  - 0 DATA_IN: RO, debounced value.
  - 1 DATA_OUT: RW.
  - 2 OUT_SET: WO, write-1-sets DATA_OUT bits.
  - 3 OUT_CLR: WO, write-1-clears DATA_OUT bits.
  - 4 EDGE_CAP: R, write-1-clears.
  - 5 IRQ_MASK: RW.
  - 6 EDGE_CFG: RW, bits[1:0]: 0 rising, 1 falling, 2 both, 3 none.
  - 7 reserved: reads 0, writes ignored.
- Address and width rules:
  - Channel index >= NUM_CH reads 0 and ignores writes.
  - Bits above WIDTH read 0 and are ignored on write.
- Read latency is exactly 1 cycle with no wait states. avs_readdata holds its last value when avs_read=0.
  - Reading WO registers returns 0.
  - Reads have no side effects.
- Input path, per channel:
  - 2-flop synchroniser, then debounce.
  - Debounce states:
    - IDLE: sync equals stable.
    - COUNT: sync differs from stable; the counter increments each cycle.
  - If sync changes value during COUNT, or returns to equal stable, the counter restarts from 0 (the latter returns to IDLE).
  - When the counter reaches DEBOUNCE_CYCLES-1 with sync unchanged, stable<=sync in that cycle, then IDLE.
  - Latency from a clean input step to DATA_IN is 2 + DEBOUNCE_CYCLES cycles. With DEBOUNCE_CYCLES=0 it is 2 cycles.
  - The counter width is $clog2(DEBOUNCE_CYCLES+1) and must not wrap.
- Edge detection is performed on stable vs its 1-cycle delayed copy, according to EDGE_CFG. A detected edge sets its EDGE_CAP bit in the following cycle.
- A W1C write to EDGE_CAP in the same cycle a new edge is detected on the same bit leaves the bit set (the edge wins).
- Output updates:
  - A DATA_OUT, OUT_SET or OUT_CLR write updates out_port in the cycle after the write strobe.
  - Only one access occurs per cycle, so set and clear never collide.
- irq is registered: irq <= OR over channels of |(EDGE_CAP & IRQ_MASK).
  - It asserts 1 cycle after a capture bit and its mask bit are both set.
  - It deasserts 1 cycle after the clearing write.
- Reset asserted mid-debounce or mid-access:
  - All state returns to reset values on that edge.
  - Any in-flight read returns 0.
  - Edges do not capture during reset.
  - The first capture is possible 2 cycles after reset deasserts, following debounce.

Decomposition:
- Package pio_pkg:
  - register offset localparams REG_DATA_IN..REG_EDGE_CFG;
  - enum edge_mode_t {EDGE_RISE, EDGE_FALL, EDGE_BOTH, EDGE_NONE}, 2 bits;
  - function for the channel slice index.
- Sub-module pio_debounce_chan (parameters WIDTH, DEBOUNCE_CYCLES):
  - contains the synchroniser, debounce FSM and edge detector;
  - outputs stable[WIDTH] and edge_pulse[WIDTH] for a given mode.
- Instantiated NUM_CH times via generate. The top level holds the register file, address decode and irq.

Test Plan:
- Reset with OUT_RESET=32'hA5: out_port channel 0 = 32'hA5, irq=0, every register read = 0 except DATA_OUT = 32'hA5.
- Write DATA_OUT ch1 = 32'h0000_00F0, OUT_SET = 32'h0F, then OUT_CLR = 32'h30 -> ch1 out_port = 32'h0000_00CF. Readback = 32'hCF one cycle after avs_read.
- DEBOUNCE_CYCLES=4: in_port ch0 bit0 0->1 with a 3-cycle glitch -> DATA_IN unchanged. Held steady -> DATA_IN=1 exactly 6 cycles after the step.
- EDGE_CFG ch2=1 (falling), IRQ_MASK bit3=1; bit3 falls -> EDGE_CAP=32'h8 and irq=1. Write EDGE_CAP=32'h8 -> irq=0 next cycle.
- W1C to EDGE_CAP ch0 bit0 in the same cycle a new rising edge is detected on bit0 -> bit remains 1 and irq stays high.
- Read channel index NUM_CH (invalid) or reg 7 -> 0. Write to it -> no register changes. Assert reset mid-COUNT -> DATA_IN=0 and the counter restarts.

Source files
------------

// File: rtl/pio_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pio_pkg : register map, edge modes and slice helper for the PIO bank  |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
package pio_pkg;

   localparam logic [2:0] REG_DATA_IN  = 3'd0;
   localparam logic [2:0] REG_DATA_OUT = 3'd1;
   localparam logic [2:0] REG_OUT_SET  = 3'd2;
   localparam logic [2:0] REG_OUT_CLR  = 3'd3;
   localparam logic [2:0] REG_EDGE_CAP = 3'd4;
   localparam logic [2:0] REG_IRQ_MASK = 3'd5;
   localparam logic [2:0] REG_EDGE_CFG = 3'd6;

   typedef enum logic [1:0] {
      EDGE_RISE = 2'd0,
      EDGE_FALL = 2'd1,
      EDGE_BOTH = 2'd2,
      EDGE_NONE = 2'd3
   } edge_mode_t;

   typedef enum logic {
      DB_IDLE  = 1'b0,
      DB_COUNT = 1'b1
   } db_state_t;

   function automatic int ch_lsb(input int ch, input int width);
      return ch * width;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pio_debounce_chan.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pio_debounce_chan : 2-flop sync, vector debounce and edge detector    |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module pio_debounce_chan
   import pio_pkg::*;
#(
   parameter int WIDTH           = 32,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_bits,
   input  edge_mode_t       mode,
   output logic [WIDTH-1:0] stable,
   output logic [WIDTH-1:0] edge_pulse
);

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [WIDTH-1:0] stable_q;
   logic [WIDTH-1:0] stable_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1    <= '0;
         sync2    <= '0;
         stable_d <= '0;
      end else begin
         sync1    <= in_bits;
         sync2    <= sync1;
         stable_d <= stable_q;
      end
   end

   if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign stable_q = sync2;
   end else begin : g_debounce
      localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

      db_state_t        state;
      db_state_t        state_nxt;
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] cnt_nxt;
      logic [WIDTH-1:0] cand;
      logic [WIDTH-1:0] cand_nxt;
      logic [WIDTH-1:0] stab;
      logic [WIDTH-1:0] stab_nxt;

      always_ff @(posedge clk) begin
         if (reset) begin
            state <= DB_IDLE;
            cnt   <= '0;
            cand  <= '0;
            stab  <= '0;
         end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            cand  <= cand_nxt;
            stab  <= stab_nxt;
         end
      end

      // cnt holds the number of cycles sync has already shown the candidate
      // value, so the cycle a new value first appears counts as the first.
      always_comb begin
         state_nxt = state;
         cnt_nxt   = cnt;
         cand_nxt  = cand;
         stab_nxt  = stab;
         if (sync2 == stab) begin
            state_nxt = DB_IDLE;
            cnt_nxt   = '0;
         end else if (state == DB_IDLE || sync2 != cand) begin
            cand_nxt = sync2;
            if (DEBOUNCE_CYCLES == 1) begin
               stab_nxt  = sync2;
               state_nxt = DB_IDLE;
               cnt_nxt   = '0;
            end else begin
               state_nxt = DB_COUNT;
               cnt_nxt   = CNT_W'(1);
            end
         end else if (cnt == CNT_LAST) begin
            stab_nxt  = sync2;
            state_nxt = DB_IDLE;
            cnt_nxt   = '0;
         end else begin
            cnt_nxt = cnt + CNT_W'(1);
         end
      end

      assign stable_q = stab;
   end

   always_comb begin
      edge_pulse = '0;
      case (mode)
         EDGE_RISE: edge_pulse = stable_q & ~stable_d;
         EDGE_FALL: edge_pulse = ~stable_q & stable_d;
         EDGE_BOTH: edge_pulse = stable_q ^ stable_d;
         default:   edge_pulse = '0;
      endcase
   end

   assign stable = stable_q;

endmodule
`default_nettype wire

// File: rtl/pio_capture_bank.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pio_capture_bank : multi-channel Avalon-MM PIO with edge capture/irq  |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module pio_capture_bank
   import pio_pkg::*;
#(
   parameter int          NUM_CH          = 4,
   parameter int          WIDTH           = 32,
   parameter int          DEBOUNCE_CYCLES = 50000,
   parameter logic [31:0] OUT_RESET       = 32'd0,
   parameter int          ADDR_W          = $clog2(NUM_CH) + 3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [ADDR_W-1:0]       avs_address,
   input  logic                    avs_read,
   input  logic                    avs_write,
   input  logic [31:0]             avs_writedata,
   output logic [31:0]             avs_readdata,
   input  logic [NUM_CH*WIDTH-1:0] in_port,
   output logic [NUM_CH*WIDTH-1:0] out_port,
   output logic                    irq
);

   logic [2:0]       reg_sel;
   logic [31:0]      ch_sel;
   logic [WIDTH-1:0] wdata;
   logic [31:0]      rd_val;

   logic [WIDTH-1:0] stable_a   [NUM_CH];
   logic [WIDTH-1:0] data_out_a [NUM_CH];
   logic [WIDTH-1:0] cap_a      [NUM_CH];
   logic [WIDTH-1:0] mask_a     [NUM_CH];
   edge_mode_t       cfg_a      [NUM_CH];
   logic [NUM_CH-1:0] ch_irq;

   // Channel indices past NUM_CH simply match no channel below.
   assign reg_sel = avs_address[2:0];
   assign ch_sel  = 32'(avs_address) >> 3;
   assign wdata   = avs_writedata[WIDTH-1:0];

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic             wr_en;
      logic             cap_clr;
      logic [WIDTH-1:0] data_out;
      logic [WIDTH-1:0] edge_cap;
      logic [WIDTH-1:0] irq_mask;
      edge_mode_t       edge_cfg;
      logic [WIDTH-1:0] stable;
      logic [WIDTH-1:0] edge_pulse;

      assign wr_en   = avs_write && (ch_sel == 32'(c));
      assign cap_clr = wr_en && (reg_sel == REG_EDGE_CAP);

      pio_debounce_chan #(
         .WIDTH           (WIDTH),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_chan (
         .clk        (clk),
         .reset      (reset),
         .in_bits    (in_port[ch_lsb(c, WIDTH) +: WIDTH]),
         .mode       (edge_cfg),
         .stable     (stable),
         .edge_pulse (edge_pulse)
      );

      always_ff @(posedge clk) begin
         if (reset) begin
            data_out <= OUT_RESET[WIDTH-1:0];
            edge_cap <= '0;
            irq_mask <= '0;
            edge_cfg <= EDGE_RISE;
         end else begin
            if (wr_en) begin
               case (reg_sel)
                  REG_DATA_OUT: data_out <= wdata;
                  REG_OUT_SET:  data_out <= data_out | wdata;
                  REG_OUT_CLR:  data_out <= data_out & ~wdata;
                  REG_IRQ_MASK: irq_mask <= wdata;
                  REG_EDGE_CFG: edge_cfg <= edge_mode_t'(avs_writedata[1:0]);
                  default: ;
               endcase
            end
            // A fresh edge is OR-ed in after the clear so it survives a
            // simultaneous W1C on the same bit.
            edge_cap <= (edge_cap & ~(wdata & {WIDTH{cap_clr}})) | edge_pulse;
         end
      end

      assign out_port[ch_lsb(c, WIDTH) +: WIDTH] = data_out;
      assign ch_irq[c]     = |(edge_cap & irq_mask);
      assign stable_a[c]   = stable;
      assign data_out_a[c] = data_out;
      assign cap_a[c]      = edge_cap;
      assign mask_a[c]     = irq_mask;
      assign cfg_a[c]      = edge_cfg;
   end

   always_comb begin
      rd_val = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (ch_sel == 32'(c)) begin
            case (reg_sel)
               REG_DATA_IN:  rd_val[WIDTH-1:0] = stable_a[c];
               REG_DATA_OUT: rd_val[WIDTH-1:0] = data_out_a[c];
               REG_EDGE_CAP: rd_val[WIDTH-1:0] = cap_a[c];
               REG_IRQ_MASK: rd_val[WIDTH-1:0] = mask_a[c];
               REG_EDGE_CFG: rd_val[1:0]       = cfg_a[c];
               default:      rd_val            = '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         avs_readdata <= '0;
         irq          <= 1'b0;
      end else begin
         if (avs_read) begin
            avs_readdata <= rd_val;
         end
         irq <= |ch_irq;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pio_capture_bank.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_pio_capture_bank : directed self-checking bench for the PIO bank   |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_pio_capture_bank;

   localparam int NUM_CH = 3;
   localparam int WIDTH  = 8;
   localparam int DEB    = 4;
   localparam int ADDR_W = 5;

   logic                    clk = 1'b0;
   logic                    reset;
   logic [ADDR_W-1:0]       avs_address;
   logic                    avs_read;
   logic                    avs_write;
   logic [31:0]             avs_writedata;
   logic [31:0]             avs_readdata;
   logic [NUM_CH*WIDTH-1:0] in_port;
   logic [NUM_CH*WIDTH-1:0] out_port;
   logic                    irq;

   int checks = 0;
   int errors = 0;
   logic [31:0] d;

   always #5 clk = ~clk;

   pio_capture_bank #(
      .NUM_CH          (NUM_CH),
      .WIDTH           (WIDTH),
      .DEBOUNCE_CYCLES (DEB),
      .OUT_RESET       (32'hA5),
      .ADDR_W          (ADDR_W)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .avs_address   (avs_address),
      .avs_read      (avs_read),
      .avs_write     (avs_write),
      .avs_writedata (avs_writedata),
      .avs_readdata  (avs_readdata),
      .in_port       (in_port),
      .out_port      (out_port),
      .irq           (irq)
   );

   function automatic logic [ADDR_W-1:0] addr(input int ch, input int r);
      return ADDR_W'(ch * 8 + r);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input int ch, input int r, input logic [31:0] data);
      @(negedge clk);
      avs_address   = addr(ch, r);
      avs_writedata = data;
      avs_write     = 1'b1;
      @(negedge clk);
      avs_write     = 1'b0;
   endtask

   task automatic rd(input int ch, input int r, output logic [31:0] data);
      @(negedge clk);
      avs_address = addr(ch, r);
      avs_read    = 1'b1;
      @(negedge clk);
      avs_read    = 1'b0;
      data        = avs_readdata;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; avs_read = 1'b0; avs_write = 1'b0;
      avs_address = '0; avs_writedata = '0; in_port = '0;
      cycles(3);
      reset = 1'b0;

      // Reset state
      check("rst_out_port", 32'(out_port), 32'h00A5A5A5);
      check("rst_irq", 32'(irq), 32'h0);
      check("rst_readdata", avs_readdata, 32'h0);
      rd(0, 0, d); check("rst_data_in", d, 32'h0);
      rd(0, 1, d); check("rst_data_out", d, 32'hA5);
      rd(0, 4, d); check("rst_edge_cap", d, 32'h0);
      rd(0, 5, d); check("rst_irq_mask", d, 32'h0);
      rd(0, 6, d); check("rst_edge_cfg", d, 32'h0);
      rd(2, 1, d); check("rst_data_out_ch2", d, 32'hA5);

      // Output register write / set / clear on ch1
      wr(1, 1, 32'h0000_00F0); check("out_write", 32'(out_port[15:8]), 32'hF0);
      wr(1, 2, 32'h0000_000F); check("out_set", 32'(out_port[15:8]), 32'hFF);
      wr(1, 3, 32'h0000_0030); check("out_clr", 32'(out_port[15:8]), 32'hCF);
      rd(1, 1, d); check("out_readback", d, 32'hCF);
      cycles(2);   check("readdata_hold", avs_readdata, 32'hCF);
      rd(1, 2, d); check("wo_reads_zero", d, 32'h0);
      wr(1, 1, 32'hFFFF_FF12);
      rd(1, 1, d); check("upper_bits_dropped", d, 32'h12);

      // Debounce: 3-cycle glitch rejected, clean step lands 6 edges later
      @(negedge clk);
      avs_address = addr(0, 0);
      avs_read    = 1'b1;
      in_port[0]  = 1'b1;
      cycles(3);
      in_port[0]  = 1'b0;
      cycles(10);
      check("glitch_rejected", avs_readdata, 32'h0);
      in_port[0]  = 1'b1;
      cycles(6);   check("debounce_edge6", avs_readdata, 32'h0);
      cycles(1);   check("debounce_edge7", avs_readdata, 32'h1);
      avs_read = 1'b0;
      rd(0, 4, d); check("rise_captured", d, 32'h1);
      check("irq_masked_off", 32'(irq), 32'h0);

      // Falling-edge capture on ch2 bit3 with interrupt
      wr(2, 6, 32'h1);
      wr(2, 5, 32'h8);
      rd(2, 5, d); check("mask_readback", d, 32'h8);
      rd(2, 6, d); check("cfg_readback", d, 32'h1);
      in_port[19] = 1'b1;
      cycles(10);
      rd(2, 4, d); check("fall_ignores_rise", d, 32'h0);
      in_port[19] = 1'b0;
      cycles(7);   check("fall_irq_edge7", 32'(irq), 32'h0);
      cycles(1);   check("fall_irq_edge8", 32'(irq), 32'h1);
      rd(2, 4, d); check("fall_captured", d, 32'h8);
      wr(2, 4, 32'h8);
      check("irq_after_clear_write", 32'(irq), 32'h1);
      cycles(1);   check("irq_cleared", 32'(irq), 32'h0);
      rd(2, 4, d); check("cap_cleared", d, 32'h0);

      // W1C colliding with a new rising edge on ch0 bit0
      wr(0, 5, 32'h1);
      cycles(1);   check("coll_irq_pre", 32'(irq), 32'h1);
      in_port[0] = 1'b0;
      cycles(10);
      in_port[0] = 1'b1;
      cycles(6);
      avs_address   = addr(0, 4);
      avs_writedata = 32'h1;
      avs_write     = 1'b1;
      cycles(1);
      avs_write     = 1'b0;
      check("coll_irq_edge7", 32'(irq), 32'h1);
      cycles(1);   check("coll_irq_edge8", 32'(irq), 32'h1);
      rd(0, 4, d); check("coll_cap_kept", d, 32'h1);
      wr(0, 4, 32'h1);
      cycles(1);   check("coll_irq_after_clear", 32'(irq), 32'h0);
      rd(0, 4, d); check("coll_cap_cleared", d, 32'h0);

      // Invalid channel and reserved register
      rd(3, 1, d); check("bad_ch_read", d, 32'h0);
      rd(0, 7, d); check("reserved_read", d, 32'h0);
      wr(3, 1, 32'hFF);
      wr(3, 2, 32'hFF);
      wr(3, 5, 32'hFF);
      wr(0, 7, 32'hFF);
      check("bad_writes_out_port", 32'(out_port), 32'h00A512A5);
      rd(0, 5, d); check("bad_writes_mask", d, 32'h1);

      // Reset in the middle of a debounce count and a read
      @(negedge clk);
      in_port[1]  = 1'b1;
      avs_address = addr(1, 1);
      avs_read    = 1'b1;
      cycles(3);   check("pre_reset_read", avs_readdata, 32'h12);
      reset = 1'b1;
      cycles(1);
      reset = 1'b0;
      check("reset_read_zero", avs_readdata, 32'h0);
      check("reset_out_port", 32'(out_port), 32'h00A5A5A5);
      check("reset_irq", 32'(irq), 32'h0);
      avs_address = addr(0, 0);
      cycles(6);   check("restart_edge6", avs_readdata, 32'h0);
      cycles(1);   check("restart_edge7", avs_readdata, 32'h3);
      avs_read = 1'b0;
      rd(0, 5, d); check("reset_mask_zero", d, 32'h0);
      check("final_irq", 32'(irq), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
